// File: rtl/dcache_pkg.sv
// Shared types and widths for the data cache port arbiter.
package dcache_pkg;

   localparam int DC_ADDR_W = 11;
   localparam int DC_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } dc_arb_state_e;

   // Request fields as latched at the accept point.
   typedef struct packed {
      logic                 write;
      logic [DC_ADDR_W-1:0] addr;
      logic [DC_DATA_W-1:0] wdata1;
      logic [DC_DATA_W-1:0] wdata2;
   } dc_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant; the priority pointer lives in the parent.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);

   // One-hot grant: a lone requester always wins, a tie goes to prio.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prio ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Two-port arbiter and access sequencer for the 2048 x 64-bit data cache array.
// Each accepted request issues one 2-word array access; the response pulses
// one cycle later on the requesting port.
module dcache_port_arbiter
   import dcache_pkg::*;
#(
   parameter int ADDR_W = DC_ADDR_W,
   parameter int DATA_W = DC_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   // port 0: load/store unit
   input  logic              req_valid_0,
   output logic              req_ready_0,
   input  logic              req_write_0,
   input  logic [ADDR_W-1:0] req_addr_0,
   input  logic [DATA_W-1:0] req_wdata1_0,
   input  logic [DATA_W-1:0] req_wdata2_0,
   output logic              resp_valid_0,
   output logic [DATA_W-1:0] resp_rdata1_0,
   output logic [DATA_W-1:0] resp_rdata2_0,
   // port 1: refill/write-back engine
   input  logic              req_valid_1,
   output logic              req_ready_1,
   input  logic              req_write_1,
   input  logic [ADDR_W-1:0] req_addr_1,
   input  logic [DATA_W-1:0] req_wdata1_1,
   input  logic [DATA_W-1:0] req_wdata2_1,
   output logic              resp_valid_1,
   output logic [DATA_W-1:0] resp_rdata1_1,
   output logic [DATA_W-1:0] resp_rdata2_1,
   // data cache array
   output logic [ADDR_W-1:0] dc_addr,
   output logic [DATA_W-1:0] dc_wdata1,
   output logic [DATA_W-1:0] dc_wdata2,
   output logic              dc_write,
   input  logic [DATA_W-1:0] dc_rdata1,
   input  logic [DATA_W-1:0] dc_rdata2
);

   dc_arb_state_e           state, state_next;
   dc_req_t                 cur;
   dc_req_t                 acc_req;
   logic                    cur_port;
   logic                    prio;
   logic [1:0]              gnt;
   logic                    accept;
   logic [1:0][DATA_W-1:0]  rd1_q;
   logic [1:0][DATA_W-1:0]  rd2_q;

   rr_arb2 u_arb (
      .req  ({req_valid_1, req_valid_0}),
      .prio (prio),
      .gnt  (gnt)
   );

   // Accepting only outside ISSUE, and never while reset is asserted.
   assign accept      = rst_n && (state != ISSUE) && (gnt != 2'b00);
   assign req_ready_0 = accept && gnt[0];
   assign req_ready_1 = accept && gnt[1];

   assign acc_req = gnt[1]
      ? '{write: req_write_1, addr: req_addr_1, wdata1: req_wdata1_1, wdata2: req_wdata2_1}
      : '{write: req_write_0, addr: req_addr_0, wdata1: req_wdata1_0, wdata2: req_wdata2_0};

   // State register; asynchronous reset drops any in-flight access at once.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state and array controls; the address is held between accesses.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_next   = state;
      dc_addr      = cur.addr;
      dc_wdata1    = '0;
      dc_wdata2    = '0;
      dc_write     = 1'b0;
      resp_valid_0 = 1'b0;
      resp_valid_1 = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_next = ISSUE;
         end
         ISSUE: begin
            dc_write   = cur.write;
            dc_wdata1  = cur.wdata1;
            dc_wdata2  = cur.wdata2;
            state_next = RESP;
         end
         RESP: begin
            resp_valid_0 = !cur_port;
            resp_valid_1 = cur_port;
            state_next   = accept ? ISSUE : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Latch the granted request and move the round-robin pointer off the winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= '0;
         cur_port <= 1'b0;
         prio     <= 1'b0;
      end else if (accept) begin
         cur      <= acc_req;
         cur_port <= gnt[1];
         prio     <= !gnt[1];
      end
   end

   // Capture load data per port at the closing edge of a read ISSUE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd1_q <= '0;
         rd2_q <= '0;
      end else if (state == ISSUE && !cur.write) begin
         rd1_q[cur_port] <= dc_rdata1;
         rd2_q[cur_port] <= dc_rdata2;
      end
   end

   // Write acknowledgements carry zero data; otherwise the last load data holds.
   assign resp_rdata1_0 = (resp_valid_0 && cur.write) ? '0 : rd1_q[0];
   assign resp_rdata2_0 = (resp_valid_0 && cur.write) ? '0 : rd2_q[0];
   assign resp_rdata1_1 = (resp_valid_1 && cur.write) ? '0 : rd1_q[1];
   assign resp_rdata2_1 = (resp_valid_1 && cur.write) ? '0 : rd2_q[1];

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a behavioural 2048 x 64 array.
module tb_dcache_port_arbiter;

   localparam int AW = 11;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid_0, req_ready_0, req_write_0, resp_valid_0;
   logic [AW-1:0] req_addr_0;
   logic [DW-1:0] req_wdata1_0, req_wdata2_0, resp_rdata1_0, resp_rdata2_0;
   logic          req_valid_1, req_ready_1, req_write_1, resp_valid_1;
   logic [AW-1:0] req_addr_1;
   logic [DW-1:0] req_wdata1_1, req_wdata2_1, resp_rdata1_1, resp_rdata2_1;
   logic [AW-1:0] dc_addr;
   logic [DW-1:0] dc_wdata1, dc_wdata2, dc_rdata1, dc_rdata2;
   logic          dc_write;

   logic [DW-1:0] mem [2048];
   logic          preload = 1'b1;
   logic [AW-1:0] addr_p1;
   int            cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   dcache_port_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_0   (req_valid_0),
      .req_ready_0   (req_ready_0),
      .req_write_0   (req_write_0),
      .req_addr_0    (req_addr_0),
      .req_wdata1_0  (req_wdata1_0),
      .req_wdata2_0  (req_wdata2_0),
      .resp_valid_0  (resp_valid_0),
      .resp_rdata1_0 (resp_rdata1_0),
      .resp_rdata2_0 (resp_rdata2_0),
      .req_valid_1   (req_valid_1),
      .req_ready_1   (req_ready_1),
      .req_write_1   (req_write_1),
      .req_addr_1    (req_addr_1),
      .req_wdata1_1  (req_wdata1_1),
      .req_wdata2_1  (req_wdata2_1),
      .resp_valid_1  (resp_valid_1),
      .resp_rdata1_1 (resp_rdata1_1),
      .resp_rdata2_1 (resp_rdata2_1),
      .dc_addr       (dc_addr),
      .dc_wdata1     (dc_wdata1),
      .dc_wdata2     (dc_wdata2),
      .dc_write      (dc_write),
      .dc_rdata1     (dc_rdata1),
      .dc_rdata2     (dc_rdata2)
   );

   // Array: combinational read of addr and addr+1 (wrapping), write at the edge.
   assign addr_p1   = dc_addr + 11'd1;
   assign dc_rdata1 = mem[dc_addr];
   assign dc_rdata2 = mem[addr_p1];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (preload) begin
         for (int i = 0; i < 2048; i++) mem[i] <= '0;
         mem[11'h100] <= 64'h0100_0001;
         mem[11'h101] <= 64'h0100_0002;
         mem[11'h200] <= 64'h0200_0001;
         mem[11'h201] <= 64'h0200_0002;
         mem[11'h020] <= 64'h5555;
         mem[11'h021] <= 64'h6666;
      end else if (dc_write) begin
         mem[dc_addr] <= dc_wdata1;
         mem[addr_p1] <= dc_wdata2;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d1, input logic [DW-1:0] d2);
      if (p == 0) begin
         req_valid_0 = v; req_write_0 = w; req_addr_0 = a; req_wdata1_0 = d1; req_wdata2_0 = d2;
      end else begin
         req_valid_1 = v; req_write_1 = w; req_addr_1 = a; req_wdata1_1 = d1; req_wdata2_1 = d2;
      end
   endtask

   function automatic logic ready_of(input int p);
      return (p == 0) ? req_ready_0 : req_ready_1;
   endfunction

   function automatic logic rv_of(input int p);
      return (p == 0) ? resp_valid_0 : resp_valid_1;
   endfunction

   function automatic logic [DW-1:0] rd1_of(input int p);
      return (p == 0) ? resp_rdata1_0 : resp_rdata1_1;
   endfunction

   function automatic logic [DW-1:0] rd2_of(input int p);
      return (p == 0) ? resp_rdata2_0 : resp_rdata2_1;
   endfunction

   // One operation on port p, started at a negedge in IDLE or RESP; ends at
   // the negedge of its own RESP cycle so the next op can go back-to-back.
   task automatic op(input string tag, input int p, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                     input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      int waited = 0;
      drive(p, 1'b1, w, a, d1, d2);
      #1;
      while (!ready_of(p) && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      check({tag, " ready"}, ready_of(p), 1);
      @(posedge clk);
      #1;
      drive(p, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check({tag, " issue dc_write"}, dc_write, w);
      check({tag, " issue dc_addr"}, dc_addr, a);
      check({tag, " issue dc_wdata1"}, dc_wdata1, w ? d1 : 64'h0);
      check({tag, " issue dc_wdata2"}, dc_wdata2, w ? d2 : 64'h0);
      check({tag, " issue ready"}, {req_ready_1, req_ready_0}, 2'b00);
      check({tag, " issue resp_valid"}, {resp_valid_1, resp_valid_0}, 2'b00);
      @(negedge clk);
      check({tag, " resp_valid"}, rv_of(p), 1);
      check({tag, " other resp_valid"}, rv_of(1 - p), 0);
      check({tag, " rdata1"}, rd1_of(p), e1);
      check({tag, " rdata2"}, rd2_of(p), e2);
      check({tag, " resp dc_write"}, dc_write, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int t0;
      int ep;
      drive(0, 1'b1, 1'b0, 11'h100, '0, '0);
      drive(1, 1'b1, 1'b0, 11'h200, '0, '0);
      repeat (3) @(negedge clk);
      preload = 1'b0;

      // Reset held with both ports valid: everything quiet.
      check("rst ready", {req_ready_1, req_ready_0}, 2'b00);
      check("rst resp_valid", {resp_valid_1, resp_valid_0}, 2'b00);
      check("rst dc_write", dc_write, 0);
      check("rst dc_addr", dc_addr, 0);
      check("rst dc_wdata1", dc_wdata1, 0);
      check("rst dc_wdata2", dc_wdata2, 0);
      check("rst rdata0", {resp_rdata1_0, resp_rdata2_0}, 0);
      check("rst rdata1", {resp_rdata1_1, resp_rdata2_1}, 0);

      // Release into contention: grants 0,1,0,1,0,1, one response every 2 cycles.
      rst_n = 1'b1;
      #1;
      for (int g = 0; g < 6; g++) begin
         if (g > 0) @(negedge clk);
         ep = g % 2;
         check($sformatf("cont%0d ready0", g), req_ready_0, (ep == 0));
         check($sformatf("cont%0d ready1", g), req_ready_1, (ep == 1));
         if (g > 0) begin
            check($sformatf("cont%0d resp prev", g), rv_of(1 - ep), 1);
            check($sformatf("cont%0d resp cur", g), rv_of(ep), 0);
            check($sformatf("cont%0d rdata1", g), rd1_of(1 - ep),
                  (ep == 1) ? 64'h0100_0001 : 64'h0200_0001);
            check($sformatf("cont%0d rdata2", g), rd2_of(1 - ep),
                  (ep == 1) ? 64'h0100_0002 : 64'h0200_0002);
         end
         @(posedge clk);
         if (g == 5) begin
            #1;
            drive(0, 1'b0, 1'b0, '0, '0, '0);
            drive(1, 1'b0, 1'b0, '0, '0, '0);
         end
         @(negedge clk);
         check($sformatf("cont%0d issue addr", g), dc_addr, (ep == 1) ? 11'h200 : 11'h100);
         check($sformatf("cont%0d issue resp", g), {resp_valid_1, resp_valid_0}, 2'b00);
      end
      @(negedge clk);
      check("cont last resp1", resp_valid_1, 1);
      check("cont last resp0", resp_valid_0, 0);
      check("cont last rdata1", resp_rdata1_1, 64'h0200_0001);

      // Single write then read-back on port 0; the read is accepted in the write's RESP.
      op("wr010", 0, 1'b1, 11'h010, 64'hAAAA_0001, 64'hAAAA_0002, 64'h0, 64'h0);
      check("wr010 mem 010", mem[11'h010], 64'hAAAA_0001);
      check("wr010 mem 011", mem[11'h011], 64'hAAAA_0002);
      op("rd010", 0, 1'b0, 11'h010, '0, '0, 64'hAAAA_0001, 64'hAAAA_0002);

      // Address wrap: block at 0x7FF covers words 0x7FF and 0x000.
      op("wr7ff", 1, 1'b1, 11'h7FF, 64'h11, 64'h22, 64'h0, 64'h0);
      check("wr7ff mem 7ff", mem[11'h7FF], 64'h11);
      check("wr7ff mem 000", mem[11'h000], 64'h22);
      op("rd7ff", 1, 1'b0, 11'h7FF, '0, '0, 64'h11, 64'h22);

      // Lone requester on port 1: four reads at one per two cycles.
      t0 = cyc;
      op("lone0", 1, 1'b0, 11'h100, '0, '0, 64'h0100_0001, 64'h0100_0002);
      op("lone1", 1, 1'b0, 11'h200, '0, '0, 64'h0200_0001, 64'h0200_0002);
      op("lone2", 1, 1'b0, 11'h010, '0, '0, 64'hAAAA_0001, 64'hAAAA_0002);
      op("lone3", 1, 1'b0, 11'h7FF, '0, '0, 64'h11, 64'h22);
      check("lone cycles", cyc - t0, 8);

      // Reset during ISSUE of a write: strobe drops at once, no response, no update.
      drive(0, 1'b1, 1'b1, 11'h020, 64'hDEAD, 64'hDEAD);
      #1;
      check("midrst ready", req_ready_0, 1);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("midrst issue dc_write", dc_write, 1);
      rst_n = 1'b0;
      #1;
      check("midrst dc_write", dc_write, 0);
      check("midrst dc_wdata1", dc_wdata1, 0);
      check("midrst resp_valid", {resp_valid_1, resp_valid_0}, 2'b00);
      @(negedge clk);
      check("midrst mem 020", mem[11'h020], 64'h5555);
      check("midrst mem 021", mem[11'h021], 64'h6666);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("midrst post%0d resp", k), {resp_valid_1, resp_valid_0}, 2'b00);
         check($sformatf("midrst post%0d dc_write", k), dc_write, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Two-port arbiter and access sequencer for the 2048 x 64-bit data cache array. Port 0 serves the load/store unit and port 1 serves the refill/write-back engine. Each accepted request issues exactly one array access: a 2-word block at `addr` and `addr+1`, read or written. The block sits between the requesters and the array and owns every array control signal.

## Interface
Parameters:
- `ADDR_W`, 11: array word-address width.
- `DATA_W`, 64: word width.

Ports (p = 0, 1; each per-port signal is one port, replicated with suffix `_p`):
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid_p`  in  1: request present.
- `req_ready_p`  out  1: arbiter accepts port p this cycle.
- `req_write_p`  in  1: 1 = store block, 0 = load block.
- `req_addr_p`  in  ADDR_W: first word address.
- `req_wdata1_p`, `req_wdata2_p`  in  DATA_W: words for `addr`, `addr+1`.
- `resp_valid_p`  out  1: one-cycle completion pulse; also sent for writes.
- `resp_rdata1_p`, `resp_rdata2_p`  out  DATA_W: load data; zero for writes.
- `dc_addr`  out  ADDR_W: array address.
- `dc_wdata1`, `dc_wdata2`  out  DATA_W: array write data.
- `dc_write`  out  1: array write strobe.
- `dc_rdata1`, `dc_rdata2`  in  DATA_W: combinational array read data.

## Operation
- FSM states are IDLE, ISSUE, RESP. Reset state is IDLE.
- Accept point: in IDLE or RESP, if any `req_valid` is high, the arbiter grants exactly one port. `req_ready_p` is high only for the granted port. The request fields are latched into `cur_*` registers and the FSM goes to ISSUE. With no request, RESP goes to IDLE.
- `req_ready` is 0 in ISSUE. Requesters hold valid and fields stable until ready; valid may not drop before then.
- Grant rule: 2-way round robin with pointer `prio`.
  - If only one port is valid, it wins.
  - If both are valid, port `prio` wins.
  - After any grant, `prio` becomes the non-granted port.
  - Reset value of `prio` is 0.
- ISSUE:
  - `dc_addr = cur_addr`.
  - `dc_wdata1/2 = cur_wdata1/2`.
  - `dc_write = cur_write`.
  - On a read, `dc_rdata1/2` is captured into the response registers at the closing edge.
  - The FSM always goes to RESP.
- RESP: `resp_valid_{cur_port}` = 1 for exactly this cycle. The other port's `resp_valid` stays 0.
- Outside ISSUE:
  - `dc_write` = 0.
  - `dc_addr` = `cur_addr`, held to keep array reads quiet.
  - `dc_wdata*` = 0.
- Address arithmetic: the arbiter never modifies the address. The array computes `addr+1` modulo 2^ADDR_W, so `addr` 2047 writes words 2047 and 0. This is legal and passed through unchanged.
- Ordering: a write completing in ISSUE updates the array at that edge. A read of the same block issued next is therefore guaranteed to see the new data, with no forwarding needed.

## Timing
- Accept edge N, ISSUE in cycle N+1, `resp_valid` in cycle N+2. Load data is valid in the same cycle as `resp_valid`.
- Back-to-back: the RESP cycle of op k is also the accept cycle of op k+1. Peak throughput is 1 access per 2 cycles. A single port alternating with itself gets this too; the round-robin pointer does not block a lone requester.
- Reset values:
  - `req_ready_*` = 0.
  - `resp_valid_*` = 0.
  - `resp_rdata*` = 0.
  - `dc_write` = 0.
  - `dc_addr` = 0.
  - `dc_wdata*` = 0.
  - FSM = IDLE, `prio` = 0.
- Reset mid-operation: asserting `rst_n` low in ISSUE forces `dc_write` to 0 immediately (asynchronous). The in-flight op is dropped with no `resp_valid`. Requesters must reissue.
- Simultaneous accept and response on the same port in RESP is legal. `resp_valid_p` and `req_ready_p` are both high in that cycle.
- `resp_rdata*` holds its value after the pulse until the next read response overwrites it.

## Structure
- `dcache_pkg`:
  - `DC_ADDR_W` = 11 and `DC_DATA_W` = 64.
  - State enum `dc_arb_state_e` {IDLE, ISSUE, RESP}.
  - Packed struct `dc_req_t` {write, addr, wdata1, wdata2}, used for the latched request.
- Sub-module `rr_arb2`:
  - Purely combinational 2-way round-robin grant.
  - Inputs: `req[1:0]`, `prio`. Outputs: one-hot `gnt[1:0]`.
  - `prio` register update stays in the parent.
- Expected size is about 180-250 lines of RTL.

## Test plan
- Reset: hold `rst_n` = 0, drive valid on both ports -> all outputs 0 and `req_ready` 0. Release -> first grant goes to port 0.
- Single write then read: port 0 writes addr 0x010 with 0xAAAA_0001 / 0xAAAA_0002, then reads 0x010.
  - Expected: write ack `resp_valid_0` at N+2, with `dc_write` high only in cycle N+1.
  - Expected: read returns 0xAAAA_0001 / 0xAAAA_0002.
- Contention: both ports hold valid reads for 6 grants.
  - Expected grant order 0,1,0,1,0,1.
  - Expected one `resp_valid` every 2 cycles, each on the matching port.
- Wrap-around: port 1 writes addr 0x7FF with 0x11 / 0x22 -> array words 0x7FF = 0x11 and 0x000 = 0x22. A read of 0x7FF returns 0x11 / 0x22.
- Reset mid-op: assert `rst_n` low during ISSUE of a write to 0x020 with 0xDEAD -> `dc_write` drops at once, no `resp_valid`, and word 0x020 is unchanged.
- Lone requester: port 1 alone issues 4 back-to-back reads -> accepts every 2 cycles, with no idle bubbles from `prio`.
